calc_text_renderer: RTL
=======================

Name: calc_text_renderer

Overview:
- Parametrised VGA text renderer for the calculator. Draws NUM_ROWS operand/result fields, each WIDTH bits wide, as either binary or hexadecimal digit glyphs.
- Operands and mode are snapshotted once per frame, so a frame never shows a mix of old and new values.
- A registered pixel pipeline meets timing.
- A frame-counted blink replaces the static error background.
- Sits between the calculator datapath and display_controller; consumes hCount/vCount/bright and drives 12-bit rgb.

Parameters:
- NUM_ROWS, 3, number of displayed fields; row 0 is the top row.
- WIDTH, 16, bits per field; must be a multiple of 4.
- H_START, 200, hCount of the left edge of digit 0.
- ROW_V0, 100, vCount of the top edge of row 0.
- ROW_PITCH, 50, vertical distance between row tops; must be at least CELL.
- CELL, 10, pixel size of one square digit cell.
- BLINK_FRAMES, 30, number of frames per blink phase while flag is set.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- bright  in  1  high inside the visible area.
- hCount  in  10  current pixel column.
- vCount  in  10  current pixel line.
- operands  in  NUM_ROWS*WIDTH  packed fields; row i = operands[i*WIDTH +: WIDTH].
- flag  in  1  error/overflow indicator.
- hex_mode  in  1  1 = hex digits, 0 = binary digits.
- rgb  out  12  pixel colour, registered.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high. On reset:
  - rgb = 12'h000
  - shadow operands = 0, shadow mode = 0
  - blink counter = 0, blink phase = 0
  - both pipeline stage valid bits = 0 (while clear, output is black)
- Frame start (FS): the cycle with hCount==0 && vCount==0.
  - At FS: shadow operands <= operands, shadow mode <= hex_mode.
  - Between FS events, changes on operands or hex_mode have no visible effect.
- Digit count: ND = WIDTH in binary mode, WIDTH/4 in hex mode.
- Geometry:
  - Row i covers vCount ROW_V0+i*ROW_PITCH through ROW_V0+i*ROW_PITCH+CELL-1.
  - Digit k covers hCount H_START+k*CELL through H_START+(k+1)*CELL-1, for k = 0..ND-1.
  - Digit k = 0 is the MSB.
  - Compute by subtraction from the start positions, not modulo, so any H_START/ROW_V0 works.
  - Local cell coordinates: c = column 0..CELL-1, r = row 0..CELL-1.
- Pipeline, fixed latency 2:
  - Stage 1 registers: hit, row index, digit value (1 bit or nibble), c, r, bright.
  - Stage 2 registers rgb.
  - rgb at cycle t+2 reflects hCount/vCount/bright at cycle t. display_controller delays hSync/vSync by 2 to match.
- Glyphs (defined for CELL=10; the glyph box is c,r = 1..8, and c or r = 0/9 is always blank):
  - Binary '1': c = 4..5, r = 1..8.
  - Binary '0': c = 3..6 on r ∈ {1,2,7,8}; c ∈ {1,2,7,8} on r = 3..6.
  - Hex: 16-entry 8x8 font ROM, bit 7 = leftmost column. Entries 0 and 1 equal the binary glyphs above.
- Colour priority:
  - !bright → 000.
  - else glyph pixel set → 000.
  - else background.
- Background:
  - flag=0 → FFF.
  - flag=1 and phase=0 → F00.
  - flag=1 and phase=1 → FFF.
- Blink:
  - While flag=1, the counter increments at each FS. On reaching BLINK_FRAMES-1 it wraps to 0 and toggles the phase.
  - On flag=0, counter and phase clear on the next clock.
  - When flag rises, the first frame shows red.
- Boundaries:
  - Pixels outside every row/digit window show background, including the area right of digit ND-1 in hex mode.
  - Rows must not overlap.
  - Reset mid-frame blanks rgb within 1 cycle. The shadow registers stay 0 until the next FS.

Test Plan:
1. Binary digit '1': reset, then row0 = 16'h8000, hex_mode=0, flag=0, run to the next FS. At hCount=204, vCount=101, rgb two cycles later = 000. At hCount=201 it is FFF. At digit 1 (hCount 211..218, vCount 103) the '0' pattern shows: 000 at c=1, FFF at c=4.
2. Hex mode: row1 = 16'hA5C3, hex_mode=1. Digits 0..3 render font A, 5, C, 3 at vCount 150..159. hCount 240..359 in that row is all FFF.
3. Frame snapshot: change operands at vCount=105. The rest of the frame shows the old value; the next frame shows the new value.
4. Blink: flag=1 with BLINK_FRAMES=2. Background over frames 0,1,2,3,4 = F00, F00, FFF, FFF, F00. After flag=0, the next frame is FFF.
5. Reset mid-frame: assert reset at hCount=205, vCount=101. rgb = 000 until valid refills. The row shows zeros until the following FS re-latches operands.
6. Latency/bright: bright low at t → rgb = 000 at t+2 regardless of glyph. Check on a checkerboard of 1000 random pixels against a reference model.

Source files
------------

// File: rtl/calc_text_renderer.sv
// Text renderer for the calculator display: draws NUM_ROWS operand fields as binary
// or hex glyphs over a white (or blinking red) background, with a 2-cycle pixel pipeline.
module calc_text_renderer #(
  parameter int NUM_ROWS     = 3,
  parameter int WIDTH        = 16,
  parameter int H_START      = 200,
  parameter int ROW_V0       = 100,
  parameter int ROW_PITCH    = 50,
  parameter int CELL         = 10,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bright,
  input  logic [9:0]                hCount,
  input  logic [9:0]                vCount,
  input  logic [NUM_ROWS*WIDTH-1:0] operands,
  input  logic                      flag,
  input  logic                      hex_mode,
  output logic [11:0]               rgb
);

  localparam int ND_HEX = WIDTH / 4;
  localparam int RW     = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int CW     = $clog2(CELL);
  localparam int KW     = $clog2(WIDTH);
  localparam int BW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // 8x8 glyphs, top row in the most significant byte, bit 7 = leftmost column.
  function automatic logic [63:0] font_glyph(input logic [3:0] d);
    case (d)
      4'h0:    font_glyph = 64'h3C3C_C3C3_C3C3_3C3C;
      4'h1:    font_glyph = 64'h1818_1818_1818_1818;
      4'h2:    font_glyph = 64'h7E06_067E_6060_607E;
      4'h3:    font_glyph = 64'h7E06_063E_0606_067E;
      4'h4:    font_glyph = 64'h6666_667E_0606_0606;
      4'h5:    font_glyph = 64'h7E60_607E_0606_067E;
      4'h6:    font_glyph = 64'h7E60_607E_6666_667E;
      4'h7:    font_glyph = 64'h7E06_060C_1818_1818;
      4'h8:    font_glyph = 64'h7E66_667E_6666_667E;
      4'h9:    font_glyph = 64'h7E66_667E_0606_067E;
      4'hA:    font_glyph = 64'h183C_6666_7E66_6666;
      4'hB:    font_glyph = 64'h7C66_667C_6666_667C;
      4'hC:    font_glyph = 64'h3E60_6060_6060_603E;
      4'hD:    font_glyph = 64'h7C66_6666_6666_667C;
      4'hE:    font_glyph = 64'h7E60_607C_6060_607E;
      default: font_glyph = 64'h7E60_607C_6060_6060;
    endcase
  endfunction

  logic [NUM_ROWS*WIDTH-1:0] r_ops;
  logic                      r_hex;
  logic [BW-1:0]             r_blink_cnt;
  logic                      r_phase;
  logic                      r_v1, r_hit1, r_bright1, r_red1;
  logic [3:0]                r_digit1;
  logic [CW-1:0]             r_c1, r_r1;
  logic                      r_v2;
  logic [11:0]               r_rgb;

  logic                      w_fs;
  int                        w_nd;
  logic                      w_row_hit, w_col_hit;
  logic [RW-1:0]             w_row;
  logic [KW-1:0]             w_k;
  logic [CW-1:0]             w_c, w_r;
  logic [WIDTH-1:0]          w_word;
  logic [3:0]                w_digit;

  // Window decode by subtracting each row/digit origin, so any start offset works.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_fs      = (hCount == 10'd0) && (vCount == 10'd0);
    w_nd      = r_hex ? ND_HEX : WIDTH;
    w_row_hit = 1'b0;
    w_row     = '0;
    w_r       = '0;
    w_col_hit = 1'b0;
    w_k       = '0;
    w_c       = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (int'(vCount) >= ROW_V0 + i*ROW_PITCH && int'(vCount) < ROW_V0 + i*ROW_PITCH + CELL) begin
        w_row_hit = 1'b1;
        w_row     = RW'(i);
        w_r       = CW'(int'(vCount) - (ROW_V0 + i*ROW_PITCH));
      end
    end
    for (int k = 0; k < WIDTH; k++) begin
      if (k < w_nd && int'(hCount) >= H_START + k*CELL && int'(hCount) < H_START + (k+1)*CELL) begin
        w_col_hit = 1'b1;
        w_k       = KW'(k);
        w_c       = CW'(int'(hCount) - (H_START + k*CELL));
      end
    end
    w_word = r_ops[int'(w_row)*WIDTH +: WIDTH];
    if (r_hex) w_digit = w_word[(ND_HEX-1-int'(w_k))*4 +: 4];
    else       w_digit = {3'b000, w_word[WIDTH-1-int'(w_k)]};
  end

  // Frame snapshot and blink counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    if (reset) begin
      r_ops       <= '0;
      r_hex       <= 1'b0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else begin
      if (w_fs) begin
        r_ops <= operands;
        r_hex <= hex_mode;
      end
      if (!flag) begin
        r_blink_cnt <= '0;
        r_phase     <= 1'b0;
      end else if (w_fs) begin
        if (r_blink_cnt == BW'(BLINK_FRAMES-1)) begin
          r_blink_cnt <= '0;
          r_phase     <= ~r_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end
    end
  end

  // Stage 1: window hit, digit value and local cell coordinates.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1      <= 1'b0;
      r_hit1    <= 1'b0;
      r_bright1 <= 1'b0;
      r_red1    <= 1'b0;
      r_digit1  <= '0;
      r_c1      <= '0;
      r_r1      <= '0;
    end else begin
      r_v1      <= 1'b1;
      r_hit1    <= w_row_hit && w_col_hit;
      r_bright1 <= bright;
      r_red1    <= flag && !r_phase;
      r_digit1  <= w_digit;
      r_c1      <= w_c;
      r_r1      <= w_r;
    end
  end

  logic [63:0] w_glyph;
  logic [7:0]  w_glyph_row;
  logic [2:0]  w_ri, w_ci;
  logic        w_in_box, w_pix;

  // Glyph box is the inner 8x8 of the cell; the outer ring is always blank.
  always_comb begin
    w_glyph     = font_glyph(r_digit1);
    w_ri        = 3'(r_r1 - 1'b1);
    w_ci        = 3'(r_c1 - 1'b1);
    w_in_box    = int'(r_c1) >= 1 && int'(r_c1) <= 8 && int'(r_r1) >= 1 && int'(r_r1) <= 8;
    w_glyph_row = w_glyph[(7-int'(w_ri))*8 +: 8];
    w_pix       = r_hit1 && w_in_box && w_glyph_row[3'd7 - w_ci];
  end

  // Stage 2: colour priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v2  <= 1'b0;
      r_rgb <= 12'h000;
    end else begin
      r_v2 <= r_v1;
      if (!r_bright1 || w_pix) r_rgb <= 12'h000;
      else if (r_red1)         r_rgb <= 12'hF00;
      else                     r_rgb <= 12'hFFF;
    end
  end

  assign rgb = r_v2 ? r_rgb : 12'h000;

endmodule
